// File: rtl/scroll_window_reader_if.sv
// Read-port bundle between the scrolling display reader and the 5-bit message RAM.
interface scroll_window_reader_if;
  logic       we_n;
  logic [4:0] address_rd;
  logic [4:0] data_rd;

  modport master (output we_n, output address_rd, input data_rd);
  modport slave  (input we_n, input address_rd, output data_rd);
endinterface

// File: rtl/scroll_window_reader.sv
// Reads a DIGITS-wide window of the message RAM each scroll tick, commits it atomically,
// and multiplexes the committed window onto common-anode digit drivers.
module scroll_window_reader #(
  parameter int unsigned MSG_LEN     = 32,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned TICK_DIV    = 25000000,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter logic [4:0]  BLANK       = 5'd31
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  scroll_window_reader_if.master  ram,
  output logic [5*DIGITS-1:0]     window_out,
  output logic [4:0]              char_sel,
  output logic [DIGITS-1:0]       an,
  output logic                    frame_valid
);

  localparam int unsigned CW = 5;
  localparam int unsigned WW = CW * DIGITS;
  localparam int unsigned KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CW-1:0] LAST_ADDR = CW'(MSG_LEN - 1);
  localparam logic [KW-1:0] LAST_K    = KW'(DIGITS - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0] LAST_REF  = RW'(REFRESH_DIV - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_FETCH_ADDR,
    S_FETCH_WAIT,
    S_COMMIT,
    S_WAIT_TICK
  } state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   k, k_nxt;
  logic [CW-1:0]   base, base_nxt;
  logic [CW-1:0]   addr_nxt, addr_inc;
  logic [WW-1:0]   shadow, shadow_nxt;
  logic [WW-1:0]   window_nxt;
  logic            fv_nxt;
  logic            tick_pending, pending_nxt;

  logic [TW-1:0]   tick_cnt;
  logic            tick;

  logic [RW-1:0]   ref_cnt;
  logic            ref_wrap;
  logic [KW-1:0]   dig;
  logic [CW-1:0]   char_cur;

  // Scroll-step divider; frozen (not cleared) while enable is low.
  assign tick = enable && (tick_cnt == LAST_TICK);

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (enable) begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end
  end

  // Window fetch sequencer: state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_LOAD;
      k              <= '0;
      base           <= '0;
      ram.address_rd <= '0;
      ram.we_n       <= 1'b1;
      shadow         <= {DIGITS{BLANK}};
      window_out     <= {DIGITS{BLANK}};
      frame_valid    <= 1'b0;
      tick_pending   <= 1'b0;
    end else begin
      state          <= state_nxt;
      k              <= k_nxt;
      base           <= base_nxt;
      ram.address_rd <= addr_nxt;
      ram.we_n       <= 1'b1;
      shadow         <= shadow_nxt;
      window_out     <= window_nxt;
      frame_valid    <= fv_nxt;
      tick_pending   <= pending_nxt;
    end
  end

  // Window fetch sequencer: next state. The address is registered on entry to FETCH_ADDR
  // so the RAM samples it at the FETCH_ADDR exit edge and data is captured one edge later.
  always_comb begin
    state_nxt   = state;
    k_nxt       = k;
    base_nxt    = base;
    addr_nxt    = ram.address_rd;
    shadow_nxt  = shadow;
    window_nxt  = window_out;
    fv_nxt      = 1'b0;
    pending_nxt = tick_pending;
    addr_inc    = (ram.address_rd == LAST_ADDR) ? '0 : ram.address_rd + CW'(1);

    if (tick && (state != S_WAIT_TICK)) begin
      pending_nxt = 1'b1;
    end

    case (state)
      S_LOAD: begin
        k_nxt     = '0;
        addr_nxt  = base;
        state_nxt = S_FETCH_ADDR;
      end
      S_FETCH_ADDR: begin
        state_nxt = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (k == KW'(i)) begin
            shadow_nxt[CW*i +: CW] = ram.data_rd;
          end
        end
        if (k == LAST_K) begin
          // Window and frame_valid change on the same edge, so frame_valid marks the new window.
          window_nxt = shadow_nxt;
          fv_nxt     = 1'b1;
          state_nxt  = S_COMMIT;
        end else begin
          k_nxt     = k + KW'(1);
          addr_nxt  = addr_inc;
          state_nxt = S_FETCH_ADDR;
        end
      end
      S_COMMIT: begin
        state_nxt = S_WAIT_TICK;
      end
      S_WAIT_TICK: begin
        if (enable && (tick || tick_pending)) begin
          base_nxt    = (base == LAST_ADDR) ? '0 : base + CW'(1);
          pending_nxt = 1'b0;
          state_nxt   = S_LOAD;
        end
      end
      default: begin
        state_nxt = S_LOAD;
      end
    endcase
  end

  // Digit refresh: free-running, independent of enable.
  assign ref_wrap = (ref_cnt == LAST_REF);

  always_comb begin
    char_cur = BLANK;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (dig == KW'(i)) begin
        char_cur = window_out[CW*i +: CW];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ref_cnt  <= '0;
      dig      <= '0;
      an       <= ~DIGITS'(1);
      char_sel <= BLANK;
    end else begin
      ref_cnt <= ref_wrap ? '0 : ref_cnt + RW'(1);
      if (ref_wrap) begin
        dig <= (dig == LAST_K) ? '0 : dig + KW'(1);
      end
      an       <= ~(DIGITS'(1) << dig);
      char_sel <= char_cur;
    end
  end

endmodule

// File: tb/tb_scroll_window_reader.sv
// Bench for scroll_window_reader: a slow (TICK_DIV=20) and a fast (TICK_DIV=5) instance,
// each checked every cycle against a timeline model, plus directed vectors and sequences.
module tb_scroll_window_reader;

  localparam int M   = 6;
  localparam int D   = 4;
  localparam int TDS = 20;
  localparam int TDF = 5;
  localparam int R   = 4;
  localparam logic [19:0] W_BLANK = 20'hFFFFF;
  localparam logic [19:0] W_1234  = {5'd4, 5'd3, 5'd2, 5'd1};

  logic clock, reset, enable;
  logic [19:0] window_s, window_f;
  logic [4:0]  csel_s, csel_f;
  logic [3:0]  an_s, an_f;
  logic        fv_s, fv_f;
  logic [4:0]  mem [0:31];

  int checks = 0;
  int errors = 0;
  bit mon_on = 0;
  bit prev_fv_s = 0, prev_fv_f = 0;

  scroll_window_reader_if ram_s ();
  scroll_window_reader_if ram_f ();

  scroll_window_reader #(.MSG_LEN(M), .DIGITS(D), .TICK_DIV(TDS), .REFRESH_DIV(R), .BLANK(5'd31)) u_slow (
    .clock(clock), .reset(reset), .enable(enable), .ram(ram_s),
    .window_out(window_s), .char_sel(csel_s), .an(an_s), .frame_valid(fv_s));

  scroll_window_reader #(.MSG_LEN(M), .DIGITS(D), .TICK_DIV(TDF), .REFRESH_DIV(R), .BLANK(5'd31)) u_fast (
    .clock(clock), .reset(reset), .enable(enable), .ram(ram_f),
    .window_out(window_f), .char_sel(csel_f), .an(an_f), .frame_valid(fv_f));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM with one-cycle registered read
  always @(posedge clock) begin
    ram_s.data_rd <= mem[ram_s.address_rd];
    ram_f.data_rd <= mem[ram_f.address_rd];
  end

  // Timeline model: p = cycles since LOAD (0 LOAD, 1..8 fetch, 9 commit, 10 idle).
  typedef struct {
    int          p;
    int          base;
    bit          pending;
    int          tcnt;
    int          rcnt;
    int          d;
    int          addr;
    logic [19:0] win;
    logic [3:0]  an;
    logic [4:0]  csel;
    bit          fv;
  } model_t;

  model_t mdl [2];

  function automatic logic [19:0] window_at(int b);
    logic [19:0] w;
    for (int j = 0; j < D; j++) w[5*j +: 5] = 5'(((b + j) % M) + 1);
    return w;
  endfunction

  function automatic model_t step(model_t m, bit rst, bit en, int td);
    model_t n = m;
    bit tick, idle, go;
    if (rst) begin
      n.p = 0; n.base = 0; n.pending = 0; n.tcnt = 0; n.rcnt = 0; n.d = 0;
      n.addr = 0; n.win = W_BLANK; n.an = 4'b1110; n.csel = 5'd31; n.fv = 0;
      return n;
    end
    tick = en && (m.tcnt == td - 1);
    idle = (m.p >= 2*D + 2);
    go   = idle && en && (tick || m.pending);
    if (tick && !idle) n.pending = 1;
    else if (go) n.pending = 0;
    if (en) n.tcnt = tick ? 0 : m.tcnt + 1;
    n.an   = ~(4'b0001 << m.d);
    n.csel = m.win[5*m.d +: 5];
    n.rcnt = (m.rcnt + 1) % R;
    if (m.rcnt == R - 1) n.d = (m.d + 1) % D;
    if (go) begin
      n.base = (m.base + 1) % M;
      n.p    = 0;
    end else if (!idle) begin
      n.p = m.p + 1;
    end
    if (n.p >= 1 && n.p <= 2*D) n.addr = (n.base + (n.p - 1) / 2) % M;
    n.fv = (n.p == 2*D + 1);
    if (n.fv) n.win = window_at(n.base);
    return n;
  endfunction

  always @(posedge clock) begin
    mdl[0] <= step(mdl[0], reset, enable, TDS);
    mdl[1] <= step(mdl[1], reset, enable, TDF);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clock) begin
    if (mon_on) begin
      chk("s_addr",   32'(ram_s.address_rd), 32'(mdl[0].addr));
      chk("s_window", 32'(window_s),         32'(mdl[0].win));
      chk("s_fv",     32'(fv_s),             32'(mdl[0].fv));
      chk("s_an",     32'(an_s),             32'(mdl[0].an));
      chk("s_csel",   32'(csel_s),           32'(mdl[0].csel));
      chk("s_we_n",   32'(ram_s.we_n),       32'd1);
      chk("s_fv_pulse", 32'(prev_fv_s & fv_s), 32'd0);
      chk("f_addr",   32'(ram_f.address_rd), 32'(mdl[1].addr));
      chk("f_window", 32'(window_f),         32'(mdl[1].win));
      chk("f_fv",     32'(fv_f),             32'(mdl[1].fv));
      chk("f_an",     32'(an_f),             32'(mdl[1].an));
      chk("f_csel",   32'(csel_f),           32'(mdl[1].csel));
      chk("f_we_n",   32'(ram_f.we_n),       32'd1);
      chk("f_fv_pulse", 32'(prev_fv_f & fv_f), 32'd0);
      prev_fv_s <= fv_s;
      prev_fv_f <= fv_f;
    end
  end

  typedef struct {
    bit          en;
    logic [4:0]  addr;
    logic        fv;
    logic [3:0]  an;
    logic [4:0]  csel;
    logic [19:0] win;
  } vec_t;

  vec_t tv [14];

  task automatic wait_frame(input int limit, output int cyc);
    cyc = 0;
    while (!fv_s && cyc < limit) begin
      @(negedge clock);
      cyc++;
    end
    if (!fv_s) chk("frame_timeout", 32'(fv_s), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [19:0] held;
    logic [19:0] exp_scroll [3];

    // reset-release vectors: cycle n after release (n=0 is LOAD)
    tv[0]  = '{1'b1, 5'd0, 1'b0, 4'b1110, 5'd31, W_BLANK};
    tv[1]  = '{1'b1, 5'd0, 1'b0, 4'b1110, 5'd31, W_BLANK};
    tv[2]  = '{1'b1, 5'd0, 1'b0, 4'b1110, 5'd31, W_BLANK};
    tv[3]  = '{1'b1, 5'd1, 1'b0, 4'b1110, 5'd31, W_BLANK};
    tv[4]  = '{1'b1, 5'd1, 1'b0, 4'b1110, 5'd31, W_BLANK};
    tv[5]  = '{1'b1, 5'd2, 1'b0, 4'b1101, 5'd31, W_BLANK};
    tv[6]  = '{1'b1, 5'd2, 1'b0, 4'b1101, 5'd31, W_BLANK};
    tv[7]  = '{1'b1, 5'd3, 1'b0, 4'b1101, 5'd31, W_BLANK};
    tv[8]  = '{1'b1, 5'd3, 1'b0, 4'b1101, 5'd31, W_BLANK};
    tv[9]  = '{1'b1, 5'd3, 1'b1, 4'b1011, 5'd31, W_1234};
    tv[10] = '{1'b1, 5'd3, 1'b0, 4'b1011, 5'd3,  W_1234};
    tv[11] = '{1'b1, 5'd3, 1'b0, 4'b1011, 5'd3,  W_1234};
    tv[12] = '{1'b1, 5'd3, 1'b0, 4'b1011, 5'd3,  W_1234};
    tv[13] = '{1'b1, 5'd3, 1'b0, 4'b0111, 5'd4,  W_1234};

    exp_scroll[0] = {5'd5, 5'd4, 5'd3, 5'd2};
    exp_scroll[1] = {5'd6, 5'd5, 5'd4, 5'd3};
    exp_scroll[2] = {5'd1, 5'd6, 5'd5, 5'd4};

    for (int i = 0; i < 32; i++) mem[i] = (i < M) ? 5'(i + 1) : 5'd0;
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clock);
    mon_on = 1;

    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clock);
      enable = tv[i].en;
      chk("tv_addr",   32'(ram_s.address_rd), 32'(tv[i].addr));
      chk("tv_fv",     32'(fv_s),             32'(tv[i].fv));
      chk("tv_an",     32'(an_s),             32'(tv[i].an));
      chk("tv_csel",   32'(csel_s),           32'(tv[i].csel));
      chk("tv_window", 32'(window_s),         32'(tv[i].win));
    end

    // three scroll ticks, the last one wrapping the address
    for (int t = 0; t < 3; t++) begin
      @(negedge clock);
      wait_frame(100, cyc);
      chk("scroll_window", 32'(window_s), 32'(exp_scroll[t]));
    end

    // freeze: window constant, no new frame on the slow instance
    enable = 1'b0;
    held   = window_s;
    repeat (100) begin
      @(negedge clock);
      chk("freeze_fv",     32'(fv_s),     32'd0);
      chk("freeze_window", 32'(window_s), 32'(held));
    end
    enable = 1'b1;

    // random enable pattern
    repeat (800) begin
      @(negedge clock);
      enable = ($urandom_range(0, 3) != 0);
    end

    // reset during the k=2 fetch
    enable = 1'b1;
    cyc = 0;
    @(negedge clock);
    while (mdl[0].p != 5 && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    chk("midfetch_reached", 32'(mdl[0].p), 32'd5);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_window", 32'(window_s),         32'(W_BLANK));
    chk("rst_an",     32'(an_s),             32'b1110);
    chk("rst_csel",   32'(csel_s),           32'd31);
    chk("rst_fv",     32'(fv_s),             32'd0);
    chk("rst_addr",   32'(ram_s.address_rd), 32'd0);
    reset = 1'b0;
    wait_frame(50, cyc);
    chk("rst_reload_latency", 32'(cyc),      32'd9);
    chk("rst_reload_window",  32'(window_s), 32'(W_1234));
    repeat (30) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scroll_window_reader.md
Name: scroll_window_reader

Overview:
- Downstream consumer of the 5-bit message RAM in the automatic scrolling display.
- Owns the RAM read port.
- Every scroll tick it reads a DIGITS-character window starting at a rotating base address, then commits the window atomically.
- Time-multiplexes the committed window onto the common-anode digit drivers.

Parameters:
- MSG_LEN, 32: number of valid message characters (addresses 0..MSG_LEN-1); legal range 1..32.
- DIGITS, 4: number of display digits, i.e. window width.
- TICK_DIV, 25000000: clock cycles per scroll step.
- REFRESH_DIV, 50000: clock cycles per digit in the multiplex refresh.
- BLANK, 31: 5-bit character code shown for an empty digit.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high.
- enable  input  1  1 = scrolling advances; 0 = freeze the current window, refresh continues.
- we_n  output  1  RAM write enable, active-low; held 1 (read) at all times by this block.
- address_rd  output  5  RAM address.
- data_rd  input  5  RAM registered read data.
- window_out  output  5*DIGITS  committed window; bits [4:0] = leftmost digit (base), next 5 bits = base+1, etc.
- char_sel  output  5  character code of the digit currently driven.
- an  output  DIGITS  digit enables, active-low, one-hot-zero.
- frame_valid  output  1  one-cycle pulse when window_out updates.

Behaviour:
- Reset values:
  - window_out: all BLANK.
  - char_sel: BLANK.
  - an: digit 0 active (all 1 except bit 0).
  - frame_valid: 0; address_rd: 0; we_n: 1.
  - base: 0; tick and refresh counters: 0; tick_pending: 0.
  - State: LOAD.
- RAM timing contract:
  - RAM samples address_rd at edge E and presents data_rd after E.
  - The block captures data_rd at edge E+1.
  - Each character therefore costs 2 cycles.
- FSM states: LOAD, FETCH_ADDR, FETCH_WAIT, COMMIT, WAIT_TICK.
- LOAD:
  - Clear digit index k to 0.
  - Next state FETCH_ADDR. Entered from reset, so the first window is loaded without waiting for a tick.
- FETCH_ADDR:
  - address_rd = (base + k) mod MSG_LEN, registered.
  - Next state FETCH_WAIT.
- FETCH_WAIT:
  - At the exit edge, shadow[k] <= data_rd.
  - If k == DIGITS-1, go to COMMIT; otherwise k++ and go to FETCH_ADDR.
- COMMIT:
  - window_out <= shadow; frame_valid = 1 for exactly this cycle.
  - Next state WAIT_TICK.
  - Fetch-to-commit latency is 2*DIGITS+1 cycles after LOAD (9 at DIGITS=4).
- WAIT_TICK:
  - On tick or tick_pending: base <= (base+1) mod MSG_LEN, clear tick_pending, go to LOAD.
  - Wraps from MSG_LEN-1 to 0. Window addresses also wrap, so the message repeats seamlessly.
- Tick counter:
  - Counts only while enable = 1; holds its value while enable = 0.
  - tick = 1 for one cycle when the count equals TICK_DIV-1, then the count returns to 0.
  - A tick arriving in any state other than WAIT_TICK sets tick_pending.
  - At most one tick is pending; further ticks are dropped.
  - If enable = 0 in WAIT_TICK, the FSM stays there and a pending tick is held.
- Window integrity: shadow is never visible. window_out changes only in COMMIT, never mid-fetch.
- Refresh:
  - Free-running counter, independent of enable.
  - Every REFRESH_DIV cycles the digit index d advances, wrapping DIGITS-1 to 0.
  - an has a 0 only at bit d; char_sel = window_out[5d+4:5d], both registered.
- Reset mid-fetch: the fetch is aborted, outputs return to reset values, and the window reloads from base 0.
- we_n never goes low, so this block never writes RAM. Writes are the upstream loader's responsibility and happen only while this block is held in reset.

Test Plan:
- Bench setup: RAM model with 1-cycle registered read; MSG_LEN=6, DIGITS=4, TICK_DIV=20, REFRESH_DIV=4; RAM[i]=i+1.
- Reset release:
  - Stimulus: release reset with enable=1.
  - Required: address_rd sequence 0,1,2,3; frame_valid at cycle 9; window_out = {4,3,2,1} (digit0 = 1); an/char_sel cycle through digits every 4 cycles.
- Scroll and wrap:
  - Stimulus: run 3 ticks.
  - Required: windows {5,4,3,2}, {6,5,4,3}, {1,6,5,4}; the base=3 window reads addresses 3,4,5,0.
- Freeze:
  - Stimulus: drop enable for 100 cycles.
  - Required: no frame_valid, window_out constant, refresh still rotating; on re-enable the next tick arrives after the remaining count, not a full count.
- Tick during fetch:
  - Stimulus: set TICK_DIV=5 so a tick lands in FETCH_WAIT.
  - Required: exactly one extra scroll immediately after COMMIT; base never skips 2.
- Reset mid-fetch:
  - Stimulus: assert reset during the k=2 fetch.
  - Required: next cycle window_out all 31, base 0, an = 4'b1110; after release, window_out = {4,3,2,1}.
- Write-port safety:
  - Stimulus: the whole run.
  - Required: we_n = 1 on every cycle; frame_valid is never high on two consecutive cycles.
